// File: rtl/reg_write_arbiter.sv
// Write-port arbiter for a Reg8bit bank: three requesters share one D bus and
// per-register En strobes, with a clear sweep. Build option: REG_ARB_FIXED_PRIO_EN.
module reg_write_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4
) (
  input  logic               CLK,
  input  logic               CLR_n,
  input  logic [2:0]         req,
  input  logic [5:0]         wr_addr,
  input  logic [3*WIDTH-1:0] wr_data,
  input  logic               clr_req,
  output logic [2:0]         gnt,
  output logic [NREG-1:0]    reg_en,
  output logic               reg_clr,
  output logic [WIDTH-1:0]   reg_d,
  output logic               busy,
  output logic [2:0]         dbg_state_o
);

  // Handshake: a requester raises req[i] with wr_addr/wr_data stable and holds
  // them until it observes gnt[i]; gnt[i] is a one-cycle pulse and the bank
  // captures reg_d into the strobed register on the following edge.

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [2:0]         gnt_q, gnt_d;
  logic [NREG-1:0]    reg_en_q, reg_en_d;
  logic               reg_clr_q, reg_clr_d;
  logic [WIDTH-1:0]   reg_d_q, reg_d_d;
  logic               busy_q, busy_d;

  logic [2:0]         eligible;
  logic [1:0]         sel;
  logic               sel_valid;
  logic [1:0]         sel_addr;
  logic [WIDTH-1:0]   sel_data;

  // A requester whose grant is high this cycle cannot be picked again now.
  assign eligible = req & ~gnt_q;

`ifdef REG_ARB_FIXED_PRIO_EN
  always_comb begin
    sel       = 2'd0;
    sel_valid = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (eligible[k]) begin
        sel       = 2'(k);
        sel_valid = 1'b1;
      end
    end
  end
`else
  logic [1:0] last_q, last_d;
  logic [1:0] cand;

  // Walk downward so the candidate nearest after last_q is the one kept.
  always_comb begin
    sel       = 2'd0;
    sel_valid = 1'b0;
    cand      = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      cand = 2'((int'(last_q) + k) % 3);
      if (eligible[cand]) begin
        sel       = cand;
        sel_valid = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == RUN && !clr_req && sel_valid) begin
      last_d = sel;
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      last_q <= 2'd2;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign sel_addr = wr_addr[int'(sel)*2 +: 2];
  assign sel_data = wr_data[int'(sel)*WIDTH +: WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = 3'b000;
    reg_en_d  = '0;
    reg_clr_d = 1'b0;
    reg_d_d   = reg_d_q;
    busy_d    = busy_q;
    case (state_q)
      CLEAR: begin
        reg_en_d  = NREG'(1) << cnt_q;
        reg_clr_d = 1'b1;
        reg_d_d   = '0;
        busy_d    = 1'b1;
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = RUN;
        end
      end
      RUN: begin
        busy_d = 1'b0;
        if (clr_req) begin
          // Soft clear wins over any pending write this cycle.
          cnt_d   = 2'd0;
          state_d = CLEAR;
          busy_d  = 1'b1;
        end else if (sel_valid) begin
          gnt_d    = 3'b001 << sel;
          reg_en_d = NREG'(1) << sel_addr;
          reg_d_d  = sel_data;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = 2'd0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q   <= CLEAR;
      cnt_q     <= 2'd0;
      gnt_q     <= 3'b000;
      reg_en_q  <= '0;
      reg_clr_q <= 1'b0;
      reg_d_q   <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      reg_en_q  <= reg_en_d;
      reg_clr_q <= reg_clr_d;
      reg_d_q   <= reg_d_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt         = gnt_q;
  assign reg_en      = reg_en_q;
  assign reg_clr     = reg_clr_q;
  assign reg_d       = reg_d_q;
  assign busy        = busy_q;
  assign dbg_state_o = {state_q, cnt_q};

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (default round-robin build): sweep,
// rotation, masking, soft clear, requests during clear, async reset abort.
module tb_reg_write_arbiter;

  logic        CLK;
  logic        CLR_n;
  logic [2:0]  req;
  logic [5:0]  wr_addr;
  logic [23:0] wr_data;
  logic        clr_req;
  logic [2:0]  gnt;
  logic [3:0]  reg_en;
  logic        reg_clr;
  logic [7:0]  reg_d;
  logic        busy;
  logic [2:0]  dbg_state_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  reg_write_arbiter #(.WIDTH(8), .NREG(4)) dut (
    .CLK         (CLK),
    .CLR_n       (CLR_n),
    .req         (req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .clr_req     (clr_req),
    .gnt         (gnt),
    .reg_en      (reg_en),
    .reg_clr     (reg_clr),
    .reg_d       (reg_d),
    .busy        (busy),
    .dbg_state_o (dbg_state_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_all(input string tag, input logic [2:0] g, input logic [3:0] e,
                            input logic c, input logic [7:0] d, input logic b);
    chk({tag, ".gnt"},     32'(gnt),     32'(g));
    chk({tag, ".reg_en"},  32'(reg_en),  32'(e));
    chk({tag, ".reg_clr"}, 32'(reg_clr), 32'(c));
    chk({tag, ".reg_d"},   32'(reg_d),   32'(d));
    chk({tag, ".busy"},    32'(busy),    32'(b));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Four sweep edges: one-hot strobe walking upward with CLR high.
  task automatic sweep(input string tag);
    step(); expect_all({tag, ".s0"}, 3'b000, 4'b0001, 1'b1, 8'h00, 1'b1);
    step(); expect_all({tag, ".s1"}, 3'b000, 4'b0010, 1'b1, 8'h00, 1'b1);
    step(); expect_all({tag, ".s2"}, 3'b000, 4'b0100, 1'b1, 8'h00, 1'b1);
    step(); expect_all({tag, ".s3"}, 3'b000, 4'b1000, 1'b1, 8'h00, 1'b1);
  endtask

  initial begin
    CLR_n   = 1'b0;
    req     = 3'b000;
    clr_req = 1'b0;
    wr_addr = 6'd0;
    wr_data = 24'd0;
    #12;
    expect_all("reset", 3'b000, 4'b0000, 1'b0, 8'h00, 1'b1);
    chk("reset.dbg", 32'(dbg_state_o), 32'(3'b000));

    @(posedge CLK); #1;
    CLR_n = 1'b1;
    sweep("init");
    step(); expect_all("init.run", 3'b000, 4'b0000, 1'b0, 8'h00, 1'b0);
    chk("init.dbg", 32'(dbg_state_o), 32'(3'b100));

    // Round-robin rotation with all three requesting.
    wr_addr = 6'b10_01_00;
    wr_data = 24'h33_22_11;
    req     = 3'b111;
    step(); expect_all("rr0", 3'b001, 4'b0001, 1'b0, 8'h11, 1'b0);
    step(); expect_all("rr1", 3'b010, 4'b0010, 1'b0, 8'h22, 1'b0);
    step(); expect_all("rr2", 3'b100, 4'b0100, 1'b0, 8'h33, 1'b0);
    req = 3'b000;
    step(); expect_all("idle", 3'b000, 4'b0000, 1'b0, 8'h33, 1'b0);

    // Lone requester held high: granted, masked for a cycle, granted again.
    wr_addr = 6'b10_01_11;
    wr_data = 24'h33_22_5A;
    req     = 3'b001;
    step(); expect_all("mask0", 3'b001, 4'b1000, 1'b0, 8'h5A, 1'b0);
    step(); expect_all("mask1", 3'b000, 4'b0000, 1'b0, 8'h5A, 1'b0);
    step(); expect_all("mask2", 3'b001, 4'b1000, 1'b0, 8'h5A, 1'b0);
    step(); expect_all("mask3", 3'b000, 4'b0000, 1'b0, 8'h5A, 1'b0);

    // Soft clear beats a simultaneous ALU request; ALU wins right after sweep.
    clr_req = 1'b1;
    step(); expect_all("clr", 3'b000, 4'b0000, 1'b0, 8'h5A, 1'b1);
    clr_req = 1'b0;
    sweep("clr");
    step(); expect_all("clr.run", 3'b001, 4'b1000, 1'b0, 8'h5A, 1'b0);
    req = 3'b000;

    // MEM request and a stray clr_req during the sweep are both held off.
    clr_req = 1'b1;
    step(); expect_all("mem.clr", 3'b000, 4'b0000, 1'b0, 8'h5A, 1'b1);
    clr_req = 1'b0;
    req     = 3'b010;
    step(); expect_all("mem.s0", 3'b000, 4'b0001, 1'b1, 8'h00, 1'b1);
    clr_req = 1'b1;
    step(); expect_all("mem.s1", 3'b000, 4'b0010, 1'b1, 8'h00, 1'b1);
    clr_req = 1'b0;
    step(); expect_all("mem.s2", 3'b000, 4'b0100, 1'b1, 8'h00, 1'b1);
    step(); expect_all("mem.s3", 3'b000, 4'b1000, 1'b1, 8'h00, 1'b1);
    step(); expect_all("mem.run", 3'b010, 4'b0010, 1'b0, 8'h22, 1'b0);

    // Async reset while the MEM grant is up.
    #2;
    CLR_n = 1'b0;
    #1;
    expect_all("arst", 3'b000, 4'b0000, 1'b0, 8'h00, 1'b1);
    req     = 3'b111;
    wr_addr = 6'b10_01_00;
    wr_data = 24'h33_22_11;
    @(posedge CLK); #1;
    expect_all("arst.hold", 3'b000, 4'b0000, 1'b0, 8'h00, 1'b1);
    CLR_n = 1'b1;
    sweep("arst");
    // Last-granted returns to IMM on reset, so ALU is first despite MEM last.
    step(); expect_all("arst.run", 3'b001, 4'b0001, 1'b0, 8'h11, 1'b0);
    req = 3'b000;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, data width of each Reg8bit register in the bank.
REQ-002 Parameter: NREG, 4, number of registers in the bank; register index is 2 bits.
REQ-003 Port: CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: CLR_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  3  write requests; bit0 = ALU, bit1 = MEM, bit2 = IMM.
REQ-006 Port: wr_addr  input  6  packed target indices {a2,a1,a0}, 2 bits per requester.
REQ-007 Port: wr_data  input  24  packed data {d2,d1,d0}, WIDTH bits per requester.
REQ-008 Port: clr_req  input  1  soft-clear request; one-cycle pulse, level also accepted.
REQ-009 Port: gnt  output  3  one-hot grant pulse, one cycle long.
REQ-010 Port: reg_en  output  4  per-register En strobes to the bank.
REQ-011 Port: reg_clr  output  1  shared CLR line to the bank.
REQ-012 Port: reg_d  output  8  shared D bus to the bank.
REQ-013 Port: busy  output  1  high while a clear sweep is in progress.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have two states, CLEAR and RUN, and a 2-bit sweep counter cnt.
REQ-016 In CLEAR, at each edge the block SHALL drive reg_en = one-hot(cnt), reg_clr = 1, reg_d = 0, gnt = 0, busy = 1, then increment cnt.
REQ-017 After the edge that drives reg_en = 4'b1000, the next edge SHALL enter RUN and drive reg_en = 0, reg_clr = 0, busy = 0.
REQ-018 In RUN, arbitration SHALL run only over eligible requests: req masked by ~gnt, so a requester whose grant is currently high is not granted again in that cycle.
REQ-019 Default policy is round-robin: search starts at the requester after the last-granted one; last-granted updates on each grant.
REQ-020 A grant decided from inputs sampled at edge k SHALL appear at edge k with, in the same cycle:
- gnt[i] = 1
- reg_en = one-hot(a_i)
- reg_d = d_i
- reg_clr = 0
The bank captures d_i at edge k+1.
REQ-021 At most one gnt bit and at most one reg_en bit SHALL be high in RUN.
REQ-022 With no eligible request, gnt = 0 and reg_en = 0; reg_d SHALL hold its last value.
REQ-023 clr_req sampled high in RUN SHALL take priority over any req in that cycle: no grant, cnt = 0, enter CLEAR.
REQ-024 clr_req and req SHALL be ignored in CLEAR; the sweep is never restarted or shortened.
REQ-025 Requesters SHALL hold req, wr_addr and wr_data stable until their gnt is seen; ungranted requests remain pending indefinitely.

Reset
REQ-026 While CLR_n = 0, regardless of CLK:
- gnt = 0, reg_en = 0, reg_clr = 0, reg_d = 0
- busy = 1, state = CLEAR, cnt = 0
- last-granted = 2, so the ALU has first priority.
REQ-027 The first rising edge after CLR_n deasserts SHALL begin the sweep (reg_en = 4'b0001).
REQ-028 CLR_n asserted mid-grant or mid-sweep SHALL abort immediately to the REQ-026 values; no partial write strobe remains.

Configuration
REQ-029 With macro REG_ARB_FIXED_PRIO_EN defined: fixed priority ALU > MEM > IMM; the last-granted register is not implemented.
REQ-030 With REG_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-019.

Verification
REQ-031 Reset release, no requests -> reg_en = 0001, 0010, 0100, 1000 on four consecutive edges with reg_clr = 1; busy falls on the 5th edge.
REQ-032 RUN, req = 3'b111 held, addresses {2,1,0}, data {0x33,0x22,0x11} -> grants 001, 010, 100 on consecutive cycles; reg_en 0001/0010/0100 with reg_d 0x11/0x22/0x33 (fixed-priority build: ALU granted repeatedly while its req stays high, gated only by REQ-018 masking).
REQ-033 RUN, req = 3'b001 and clr_req = 1 at the same edge -> gnt = 0 and a full 4-cycle sweep; ALU granted on the first RUN cycle after the sweep.
REQ-034 req[1] = 1 during CLEAR -> no gnt until busy = 0; the MEM grant is the first RUN output.
REQ-035 CLR_n pulsed low while gnt = 3'b010 -> all outputs zero asynchronously; busy = 1; the sweep restarts after release.
